// File: rtl/sysarray_pkg.sv
// Shared types and timing constants for the systolic array operand feeder.
package sysarray_pkg;

  localparam int unsigned NDefault  = 4;
  localparam int unsigned DWDefault = 32;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStream,
    StDrain,
    StFin
  } state_e;

  function automatic int unsigned stream_last(input int unsigned n);
    return 2 * n - 2;
  endfunction

  function automatic int unsigned drain_last(input int unsigned n);
    return 3 * n - 3;
  endfunction

  // Counter width covering t = 0 .. 3N-2.
  function automatic int unsigned t_width(input int unsigned n);
    return $clog2(3 * n - 1);
  endfunction

  localparam int unsigned T_STREAM_LAST = 2 * NDefault - 2;
  localparam int unsigned T_DRAIN_LAST  = 3 * NDefault - 3;

endpackage

// File: rtl/feed_lane.sv
// One skewed operand lane: stores an N-entry vector and presents vec[t-Idx] while streaming.
module feed_lane
  import sysarray_pkg::*;
#(
  parameter int unsigned N   = NDefault,
  parameter int unsigned DW  = DWDefault,
  parameter int unsigned TW  = 4,
  parameter int unsigned Idx = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [$clog2(N)-1:0] wr_idx,
  input  logic [DW-1:0]        wr_data,
  input  logic [TW-1:0]        t,
  input  logic                 active,
  output logic [DW-1:0]        lane_data
);

  localparam int unsigned IW = $clog2(N);

  logic [DW-1:0] vec_q [N];
  logic [TW-1:0] k;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        vec_q[i] <= '0;
      end
    end else if (wr_en) begin
      vec_q[wr_idx] <= wr_data;
    end
  end

  // Lane Idx lags lane 0 by Idx cycles, producing the diagonal skew.
  always_comb begin
    lane_data = '0;
    k         = t - TW'(Idx);
    if (active && (t >= TW'(Idx)) && (k < TW'(N))) begin
      lane_data = vec_q[k[IW-1:0]];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for an NxN systolic array: buffers A/B, then streams skewed west/north lanes.
// Optional SYSFEED_RUN_COUNT_EN adds a saturating completed-run counter output.
module systolic_feeder
  import sysarray_pkg::*;
#(
  parameter int unsigned N  = NDefault,
  parameter int unsigned DW = DWDefault
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  output logic                 wr_ready,
  input  logic                 wr_mat,
  input  logic [$clog2(N)-1:0] wr_row,
  input  logic [$clog2(N)-1:0] wr_col,
  input  logic [DW-1:0]        wr_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 arr_rst,
  output logic [N*DW-1:0]      west_data,
  output logic [N*DW-1:0]      north_data,
`ifdef SYSFEED_RUN_COUNT_EN
  output logic [15:0]          run_count,
`endif
  output logic                 done
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned TW = t_width(N);
  localparam logic [TW-1:0] TStreamLast = TW'(stream_last(N));
  localparam logic [TW-1:0] TDrainLast  = TW'(drain_last(N));

  state_e          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic            stream_d;
  logic            wr_accept;
  logic [N*DW-1:0] west_lane;
  logic [N*DW-1:0] north_lane;

  assign wr_accept = wr_en && (state_q == StIdle);
  assign stream_d  = (state_d == StStream);

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StClear;
      end
      StClear: begin
        state_d = StStream;
        t_d     = '0;
      end
      StStream: begin
        t_d = t_q + 1'b1;
        if (t_q == TStreamLast) state_d = StDrain;
      end
      StDrain: begin
        if (t_q == TDrainLast) begin
          state_d = StFin;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        t_d     = '0;
      end
    endcase
  end

  // Lanes are fed the next-cycle t so that the registered outputs line up with t_q.
  for (genvar g = 0; g < N; g++) begin : g_lane
    feed_lane #(
      .N  (N),
      .DW (DW),
      .TW (TW),
      .Idx(g)
    ) u_west (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_accept && !wr_mat && (wr_row == IW'(g))),
      .wr_idx   (wr_col),
      .wr_data  (wr_data),
      .t        (t_d),
      .active   (stream_d),
      .lane_data(west_lane[g*DW +: DW])
    );

    feed_lane #(
      .N  (N),
      .DW (DW),
      .TW (TW),
      .Idx(g)
    ) u_north (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_accept && wr_mat && (wr_col == IW'(g))),
      .wr_idx   (wr_row),
      .wr_data  (wr_data),
      .t        (t_d),
      .active   (stream_d),
      .lane_data(north_lane[g*DW +: DW])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      t_q        <= '0;
      west_data  <= '0;
      north_data <= '0;
      arr_rst    <= 1'b0;
      done       <= 1'b0;
      wr_ready   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      west_data  <= west_lane;
      north_data <= north_lane;
      arr_rst    <= (state_d == StClear);
      done       <= (state_d == StFin);
      wr_ready   <= (state_d == StIdle);
      busy       <= (state_d != StIdle);
    end
  end

`ifdef SYSFEED_RUN_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      run_count <= '0;
    end else if ((state_d == StFin) && (run_count != 16'hFFFF)) begin
      run_count <= run_count + 16'd1;
    end
  end
`endif

endmodule
